// File: rtl/reg_file_wb.sv
// 32-entry register file: one-hot write decode, two combinational read ports,
// register 0 hard-wired to zero, optional same-cycle write forwarding.

module reg_file_wb_cell #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             CLRN,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN)   q <= '0;
    else if (we) q <= d;
  end
endmodule

module reg_file_wb #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic                 CLK,
  input  logic                 CLRN,
  input  logic                 WE,
  input  logic [ADDR_W-1:0]    WN,
  input  logic [WIDTH-1:0]     D,
  input  logic [ADDR_W-1:0]    RNA,
  input  logic [ADDR_W-1:0]    RNB,
  output logic [WIDTH-1:0]     QA,
  output logic [WIDTH-1:0]     QB,
  output logic [2**ADDR_W-1:0] WDEC
);
  localparam int DEPTH = 2**ADDR_W;

  logic [WIDTH-1:0] regs [DEPTH];

  // Entry 0 has no storage; its decode bit is tied low so writes to it vanish.
  assign regs[0] = '0;
  assign WDEC[0] = 1'b0;

  // WE gates first so an unknown WN with WE=0 still yields a clean zero strobe.
  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_reg
      assign WDEC[gi] = WE & CLRN & (WN == ADDR_W'(gi));
      reg_file_wb_cell #(.WIDTH(WIDTH)) u_cell (
        .CLK  (CLK),
        .CLRN (CLRN),
        .we   (WDEC[gi]),
        .d    (D),
        .q    (regs[gi])
      );
    end
  endgenerate

  // WDEC already folds in WE, CLRN and WN!=0, so it doubles as the forward hit.
  always_comb begin
    QA = regs[RNA];
    QB = regs[RNB];
    if (BYPASS != 0 && WDEC[RNA]) QA = D;
    if (BYPASS != 0 && WDEC[RNB]) QB = D;
    if (!CLRN) begin
      QA = '0;
      QB = '0;
    end
  end
endmodule

// File: tb/tb_reg_file_wb.sv
// Checks reg_file_wb (forwarding and non-forwarding builds side by side)
// against an array model of the register contents.
`timescale 1ns/1ps
module tb_reg_file_wb;
  logic        CLK = 1'b0;
  logic        clrn, we;
  logic [4:0]  wn, rna, rnb;
  logic [31:0] d;
  logic [31:0] qa1, qb1, wdec1, qa0, qb0, wdec0;

  logic [31:0] mem [32];
  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  reg_file_wb #(.WIDTH(32), .ADDR_W(5), .BYPASS(1)) u_bp1 (
    .CLK(CLK), .CLRN(clrn), .WE(we), .WN(wn), .D(d),
    .RNA(rna), .RNB(rnb), .QA(qa1), .QB(qb1), .WDEC(wdec1));

  reg_file_wb #(.WIDTH(32), .ADDR_W(5), .BYPASS(0)) u_bp0 (
    .CLK(CLK), .CLRN(clrn), .WE(we), .WN(wn), .D(d),
    .RNA(rna), .RNB(rnb), .QA(qa0), .QB(qb0), .WDEC(wdec0));

  function automatic logic [31:0] exp_q(bit bp, logic [4:0] rn);
    if (clrn !== 1'b1 || rn == 5'd0) return 32'h0;
    if (bp && we === 1'b1 && wn != 5'd0 && rn == wn) return d;
    return mem[rn];
  endfunction

  function automatic logic [31:0] exp_wdec();
    logic [31:0] r;
    r = '0;
    if (clrn === 1'b1 && we === 1'b1 && wn != 5'd0) r[wn] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_qa_bp1"}, qa1, exp_q(1'b1, rna));
    chk({tag, "_qb_bp1"}, qb1, exp_q(1'b1, rnb));
    chk({tag, "_qa_bp0"}, qa0, exp_q(1'b0, rna));
    chk({tag, "_qb_bp0"}, qb0, exp_q(1'b0, rnb));
    chk({tag, "_wdec1"}, wdec1, exp_wdec());
    chk({tag, "_wdec0"}, wdec0, exp_wdec());
  endtask

  task automatic drive(input logic w, input logic [4:0] n, input logic [31:0] dat,
                       input logic [4:0] ra, input logic [4:0] rb);
    @(negedge CLK);
    we = w; wn = n; d = dat; rna = ra; rnb = rb;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    if (clrn === 1'b1 && we === 1'b1 && wn != 5'd0) mem[wn] = d;
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
  endtask

  initial begin
    clrn = 1'b0; we = 1'b0; wn = '0; d = '0; rna = '0; rnb = '0;
    clear_model();
    #12;
    rna = 5'd1; rnb = 5'd31; #1;
    check_all("reset_held");
    @(negedge CLK); clrn = 1'b1; #1;
    check_all("reset_released");

    // Randomized writes and reads
    for (int k = 0; k < 60; k++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom), $urandom, 5'($urandom), 5'($urandom));
      check_all("rand_pre");
      tick();
      check_all("rand_post");
    end

    // Reset pulse without a clock edge clears everything, even with a live write
    drive(1'b1, 5'd9, 32'h1234_5678, 5'd9, 5'd10);
    clrn = 1'b0;
    #1;
    clear_model();
    for (int i = 0; i < 8; i++) begin
      rna = 5'(i * 4 + 1); rnb = 5'(31 - i * 4); #0.5;
      check_all("async_clear");
    end
    @(negedge CLK); clrn = 1'b1; #1;

    // Basic write and neighbour read
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd6);
    check_all("w5_pre");
    chk("w5_wdec_literal", wdec1, 32'h0000_0020);
    tick();
    check_all("w5_post");
    chk("w5_qa_literal", qa0, 32'hDEAD_BEEF);

    // Writes to register 0 vanish
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    check_all("w0_pre");
    tick();
    check_all("w0_post");

    // Forwarding vs no forwarding
    drive(1'b1, 5'd7, 32'h1, 5'd7, 5'd7);
    tick();
    drive(1'b1, 5'd7, 32'h2, 5'd7, 5'd7);
    check_all("fwd_pre");
    chk("fwd_bp1_literal", qa1, 32'h2);
    chk("fwd_bp0_literal", qb0, 32'h1);
    tick();
    check_all("fwd_post");

    // Fill every register, then sweep both ports
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), 32'(i) * 32'h0101_0101, 5'(i), 5'(32 - i));
      tick();
    end
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      check_all("sweep");
    end

    // Unknown write number with WE low must leave all registers intact
    drive(1'b0, 5'bx, 32'hBAD0_BAD0, 5'd3, 5'd4);
    tick();
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      check_all("x_wn");
    end

    // Reset coincident with a write edge wins; first write after release lands
    drive(1'b1, 5'd3, 32'd9, 5'd3, 5'd3);
    #3 clrn = 1'b0;
    clear_model();
    tick();
    check_all("rst_edge");
    @(negedge CLK); clrn = 1'b1; #1;
    check_all("rel_pre");
    tick();
    check_all("rel_post");
    chk("rel_reg3_literal", qa0, 32'd9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
